// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data RAM.
// Round-robin grant with burst lock, one registered issue stage, and read-data routing back to the requester.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_we,
  input  logic                r0_lock,
  output logic                r0_rsp_valid,
  output logic [DATA_W-1:0]   r0_rsp_rdata,
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_we,
  input  logic                r1_lock,
  output logic                r1_rsp_valid,
  output logic [DATA_W-1:0]   r1_rsp_rdata,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W         = DATA_W / 8;
  localparam int unsigned LOCK_TIMEOUT = 16;
  localparam int unsigned TO_W         = $clog2(LOCK_TIMEOUT);

  typedef enum logic [0:0] {ARB_OPEN, ARB_LOCKED} arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   we;
  } mem_req_t;

  arb_state_t      state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            gnt0_c, gnt1_c, accept_c, gnt_idx_c, acc_lock_c, owner_valid_c;
  mem_req_t        req_c;
  logic            rd_pending_q, rd_id_q;

  // Arbitration state: round-robin pointer, lock owner, idle-timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_OPEN;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    to_cnt_d      = to_cnt_q;
    gnt0_c        = 1'b0;
    gnt1_c        = 1'b0;
    owner_valid_c = owner_q ? r1_valid : r0_valid;

    case (state_q)
      ARB_OPEN: begin
        gnt0_c = r0_valid && (!r1_valid || last_q);
        gnt1_c = r1_valid && !gnt0_c;
      end
      ARB_LOCKED: begin
        gnt0_c = !owner_q && r0_valid;
        gnt1_c = owner_q && r1_valid;
      end
      default: ;
    endcase

    if (reset) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end

    accept_c   = gnt0_c || gnt1_c;
    gnt_idx_c  = gnt1_c;
    acc_lock_c = gnt1_c ? r1_lock : r0_lock;

    // A handshake decides the lock; an idle owner only burns down the timeout
    if (accept_c) begin
      last_d   = gnt_idx_c;
      to_cnt_d = '0;
      if (acc_lock_c) begin
        state_d = ARB_LOCKED;
        owner_d = gnt_idx_c;
      end else begin
        state_d = ARB_OPEN;
      end
    end else if (state_q == ARB_LOCKED && !owner_valid_c) begin
      if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
        state_d  = ARB_OPEN;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_comb begin
    req_c.addr  = gnt1_c ? r1_addr  : r0_addr;
    req_c.wdata = gnt1_c ? r1_wdata : r0_wdata;
    req_c.we    = gnt1_c ? r1_we    : r0_we;
  end

  assign r0_ready = gnt0_c;
  assign r1_ready = gnt1_c;

  // Issue stage: drains every cycle, so no stall path back to the requesters
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= '0;
      rd_pending_q <= 1'b0;
      rd_id_q      <= 1'b0;
    end else begin
      mem_en       <= accept_c;
      rd_pending_q <= accept_c && (req_c.we == '0);
      rd_id_q      <= gnt_idx_c;
      if (accept_c) begin
        mem_addr  <= req_c.addr;
        mem_wdata <= req_c.wdata;
        mem_we    <= req_c.we;
      end else begin
        mem_we    <= '0;
      end
    end
  end

  // Response flags line up with the RAM's one-cycle read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else begin
      r0_rsp_valid <= rd_pending_q && !rd_id_q;
      r1_rsp_valid <= rd_pending_q && rd_id_q;
    end
  end

  assign r0_rsp_rdata = r0_rsp_valid ? mem_rdata : '0;
  assign r1_rsp_rdata = r1_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference arbiter model predicts grants and memory traffic,
// a separate monitor checks the issue stage and read responses against the expected queues.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_ready, r0_lock, r0_rsp_valid;
  logic [31:0] r0_addr, r0_wdata, r0_rsp_rdata;
  logic [3:0]  r0_we;
  logic        r1_valid, r1_ready, r1_lock, r1_rsp_valid;
  logic [31:0] r1_addr, r1_wdata, r1_rsp_rdata;
  logic [3:0]  r1_we;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_we(r0_we), .r0_lock(r0_lock), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_we(r1_we), .r1_lock(r1_lock), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic [31:0] addr; logic [31:0] wdata; logic [3:0] we; } iss_t;
  typedef struct { int unsigned due; bit id; logic [31:0] data; } rsp_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] ram    [logic [29:0]];
  logic [31:0] shadow [logic [29:0]];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  bit m_last   = 1'b1;
  bit m_locked = 1'b0;
  bit m_owner  = 1'b0;
  int m_idle   = 0;
  int g_last;
  bit rdy0_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] rd_word(input bit use_shadow, input logic [29:0] w);
    if (use_shadow) return shadow.exists(w) ? shadow[w] : init_word(w);
    return ram.exists(w) ? ram[w] : init_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM with one-cycle read latency; garbage on the bus otherwise
  always @(posedge clk) begin
    if (mem_en && mem_we == 4'b0000) begin
      mem_rdata <= rd_word(1'b0, mem_addr[31:2]);
    end else begin
      if (mem_en) ram[mem_addr[31:2]] = merge(rd_word(1'b0, mem_addr[31:2]), mem_wdata, mem_we);
      mem_rdata <= $urandom;
    end
  end

  // Monitor: every cycle either an expected item is due or the outputs must be quiet
  iss_t mon_i;
  rsp_t mon_r;
  always @(negedge clk) begin
    if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
      mon_i = iss_q.pop_front();
      chk("mem_en", 64'(mem_en), 64'(1'b1));
      chk("mem_addr", 64'(mem_addr), 64'(mon_i.addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(mon_i.wdata));
      chk("mem_we", 64'(mem_we), 64'(mon_i.we));
    end else begin
      chk("mem_en_idle", 64'(mem_en), 64'(1'b0));
    end
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      mon_r = rsp_q.pop_front();
      chk("r0_rsp_valid", 64'(r0_rsp_valid), 64'(mon_r.id == 1'b0));
      chk("r1_rsp_valid", 64'(r1_rsp_valid), 64'(mon_r.id == 1'b1));
      chk("rsp_rdata", 64'(mon_r.id ? r1_rsp_rdata : r0_rsp_rdata), 64'(mon_r.data));
      chk("rsp_rdata_other", 64'(mon_r.id ? r0_rsp_rdata : r1_rsp_rdata), 64'(0));
    end else begin
      chk("rsp_valid_idle", 64'({r0_rsp_valid, r1_rsp_valid}), 64'(0));
      chk("rsp_rdata_idle", 64'({r0_rsp_rdata, r1_rsp_rdata}), 64'(0));
    end
  end

  // One clock of reference model: predicts the grant from current inputs and records expected traffic
  task automatic cycle();
    int          eg;
    bit          lk;
    logic [31:0] a, d;
    logic [3:0]  we;
    iss_t        ei;
    rsp_t        er;
    @(negedge clk);
    eg = -1;
    if (!reset) begin
      if (m_locked) begin
        if (m_owner ? r1_valid : r0_valid) eg = m_owner ? 1 : 0;
      end else if (r0_valid && r1_valid) eg = m_last ? 0 : 1;
      else if (r0_valid) eg = 0;
      else if (r1_valid) eg = 1;
    end
    chk("r0_ready", 64'(r0_ready), 64'(eg == 0));
    chk("r1_ready", 64'(r1_ready), 64'(eg == 1));
    rdy0_last = r0_ready;
    if (reset) begin
      m_last = 1'b1; m_locked = 1'b0; m_idle = 0;
      while (iss_q.size() > 0 && iss_q[$].due > cyc) void'(iss_q.pop_back());
      while (rsp_q.size() > 0 && rsp_q[$].due > cyc) void'(rsp_q.pop_back());
    end else if (eg >= 0) begin
      a  = (eg == 1) ? r1_addr  : r0_addr;
      d  = (eg == 1) ? r1_wdata : r0_wdata;
      we = (eg == 1) ? r1_we    : r0_we;
      lk = (eg == 1) ? r1_lock  : r0_lock;
      ei.due = cyc + 1; ei.addr = a; ei.wdata = d; ei.we = we;
      iss_q.push_back(ei);
      if (we == 4'b0000) begin
        er.due = cyc + 2; er.id = (eg == 1); er.data = rd_word(1'b1, a[31:2]);
        rsp_q.push_back(er);
      end else begin
        shadow[a[31:2]] = merge(rd_word(1'b1, a[31:2]), d, we);
      end
      m_last = (eg == 1);
      m_idle = 0;
      if (m_locked && !lk) m_locked = 1'b0;
      else if (lk) begin m_locked = 1'b1; m_owner = (eg == 1); end
    end else if (m_locked && !(m_owner ? r1_valid : r0_valid)) begin
      m_idle++;
      if (m_idle == 16) begin m_locked = 1'b0; m_idle = 0; end
    end
    g_last = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid = 1'b0; r0_addr = '0; r0_wdata = '0; r0_we = '0; r0_lock = 1'b0;
    r1_valid = 1'b0; r1_addr = '0; r1_wdata = '0; r1_we = '0; r1_lock = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a0, a1, n, blocked;
    reset = 1'b1;
    idle_inputs();
    repeat (3) cycle();
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("reset_mem_we", 64'(mem_we), 64'(0));
    chk("reset_mem_en", 64'(mem_en), 64'(0));
    reset = 1'b0;
    repeat (2) cycle();

    // Single read from r0 at 0x10
    r0_valid = 1'b1; r0_addr = 32'h10;
    cycle();
    idle_inputs();
    repeat (4) cycle();

    // Both requesters streaming reads
    a0 = 0; a1 = 0;
    for (int i = 0; i < 10; i++) begin
      r0_valid = 1'b1; r0_addr = 32'h100 + 32'(a0);
      r1_valid = 1'b1; r1_addr = 32'h200 + 32'(a1);
      cycle();
      if (g_last == 0) a0 += 4;
      if (g_last == 1) a1 += 4;
    end
    idle_inputs();
    repeat (3) cycle();

    // r1 locked burst of four full-word writes while r0 keeps asking
    n = 0; a0 = 0;
    for (int i = 0; i < 24 && n < 4; i++) begin
      r0_valid = 1'b1; r0_addr = 32'h300 + 32'(a0);
      r1_valid = 1'b1; r1_addr = 32'(4 * n); r1_we = 4'b1111;
      r1_wdata = $urandom; r1_lock = (n < 3);
      cycle();
      if (g_last == 1) n++;
      if (g_last == 0) a0 += 4;
    end
    chk("lock_burst_done", 64'(n), 64'(4));
    idle_inputs();
    r0_valid = 1'b1; r0_addr = 32'h0;
    cycle();
    idle_inputs();
    repeat (3) cycle();

    // Lock owner r1 goes idle with the lock held: r0 waits out the timeout
    r1_valid = 1'b1; r1_lock = 1'b1; r1_addr = 32'h40; r1_we = 4'b1111; r1_wdata = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (g_last == 1) break;
    end
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_addr = 32'h40;
    blocked = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (rdy0_last) break;
      blocked++;
    end
    chk("timeout_block_cycles", 64'(blocked), 64'(16));
    idle_inputs();
    repeat (3) cycle();

    // Byte write then read-back of the merged word
    r0_valid = 1'b1; r0_addr = 32'h7; r0_we = 4'b0100; r0_wdata = 32'hAABB_CCDD;
    cycle();
    r0_we = 4'b0000; r0_addr = 32'h4;
    cycle();
    idle_inputs();
    repeat (3) cycle();

    // Reset the cycle after a read handshake: the read must vanish
    r0_valid = 1'b1; r0_addr = 32'h10;
    cycle();
    idle_inputs();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (3) cycle();

    // Randomised traffic with locks, byte writes and occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      r0_valid = ($urandom_range(0, 2) != 0);
      r0_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      r0_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      r0_wdata = $urandom;
      r0_lock  = ($urandom_range(0, 7) == 0);
      r1_valid = ($urandom_range(0, 2) != 0);
      r1_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      r1_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      r1_wdata = $urandom;
      r1_lock  = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (4) cycle();
    chk("issue_queue_drained", 64'(iss_q.size()), 64'(0));
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
